pwm_multi_channel: RTL
======================

Name: pwm_multi_channel

Overview:
- Parametrised multi-channel PWM generator. One shared period counter drives CHANNELS independent duty comparators.
- Supports edge-aligned and centre-aligned modes.
- Period, duty and mode are double-buffered: a software update takes effect only at a period boundary, so no glitched or truncated pulses.
- Sits between the control register block and the motor/LED driver pins.

Parameters:
- WIDTH, 8, bit width of the counter, period and each duty value.
- CHANNELS, 4, number of PWM outputs sharing the counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run control; low holds the counter and forces outputs low.
- update  input  1  one-cycle strobe; captures period, duty and center_mode into pending registers.
- period  input  WIDTH  terminal count (edge-mode period = period+1 cycles).
- duty  input  CHANNELS*WIDTH  packed duty values; channel i is duty[i*WIDTH +: WIDTH].
- center_mode  input  1  0 = edge-aligned, 1 = centre-aligned.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_start  output  1  one-cycle pulse marking the first cycle of each period.

Behaviour:
- Reset (reset_n low, asynchronous):
  - counter = 0, direction = up, pending_valid = 0.
  - Active period = all ones, active duty = 0, active mode = edge.
  - pwm_out = 0, period_start = 0.
- Active vs pending:
  - Active registers drive the counter and comparators.
  - update=1 copies period/duty/center_mode into pending registers and sets pending_valid.
  - A later update before the boundary overwrites the pending registers (last write wins).
- Boundary: the cycle on which the counter is loaded with 0.
  - On the boundary, if pending_valid, pending is copied to active and pending_valid is cleared.
  - If update coincides with a boundary, the update's own values go straight to active; pending_valid ends at 0.
- Edge mode:
  - Counter increments by 1.
  - When counter == active period, the next value is 0 (boundary).
  - Period length = period+1 cycles.
- Centre mode:
  - Counter counts up to the active period, then down.
  - When counter == 1 while counting down, the next value is 0 (boundary); direction then becomes up.
  - Period length = 2*period cycles.
  - period == 0: counter stays at 0, and every cycle is a boundary.
- Compare:
  - pwm_out[i] is registered as (next counter value < active duty[i]), evaluated against the active values in force for that counter value.
  - Output therefore aligns with the counter value it represents; there is no extra latency beyond the register.
  - duty = 0 gives constant low. Duty greater than the maximum counter value gives constant high.
- period_start is registered high on every boundary cycle, aligned with pwm_out for counter value 0.
- enable low:
  - counter = 0, direction = up, pwm_out = 0, period_start = 0.
  - A pending update is applied immediately; update strobes still capture.
- enable rising: the first enabled cycle is a boundary (counter value 0, period_start = 1).
- Mode change is shadowed like period/duty. On transfer, direction is forced to up.
- Reset mid-period: outputs drop to 0 asynchronously and pending updates are discarded.

Optional Feature:
- Macro: PWM_POLARITY_EN.
- Defined:
  - Adds input port polarity[CHANNELS].
  - pwm_out[i] = compare result XOR polarity[i], applied inside the output register. This also applies while enable is low.
  - Reset still forces pwm_out = 0 until the first clock edge after reset_n releases.
- Undefined: no polarity port; outputs are active-high.

Test Plan (WIDTH=8, CHANNELS=4):
- Defaults: release reset, enable=1, no update -> all pwm_out = 0 indefinitely; period_start pulses every 256 cycles.
- Edge mode: with enable=0, update period=9, duty={ch3=5, ch2=10, ch1=0, ch0=3}, then enable=1 -> per 10-cycle period, ch0 high 3 cycles, ch1 always low, ch2 always high, ch3 high 5 cycles; period_start every 10 cycles.
- Shadowing: in the previous setup, update ch0 duty=7 when counter=4 -> current period keeps 3 high cycles; every following period has 7.
- Centre mode: update period=4, center_mode=1, duty ch0=2 -> counter 0,1,2,3,4,3,2,1 repeating (8 cycles); ch0 high for counter values 0,1,1 (3 cycles); period_start every 8 cycles.
- Update on boundary: assert update exactly on a boundary cycle with period=4 (edge) -> the new 5-cycle period starts on that boundary.
- Async reset: drop reset_n mid-period while ch2 is high -> pwm_out = 0 before the next clk edge; after release, defaults as in the first scenario.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared-counter PWM with edge/centre alignment and period-boundary double buffering.
// Optional PWM_POLARITY_EN adds a per-channel output polarity input.
module pwm_multi_channel #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      update,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      center_mode,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0]       polarity,
`endif
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);
  logic [WIDTH-1:0] cnt, cnt_nxt, a_per, p_per, n_per;
  logic [CHANNELS*WIDTH-1:0] a_duty, p_duty, n_duty, eff_duty;
  logic a_mode, p_mode, n_mode, pv, down, run, wrap, bnd, turn;
  logic [CHANNELS-1:0] cmp, pol;
`ifdef PWM_POLARITY_EN
  assign pol = polarity;
`else
  assign pol = '0;
`endif
  always_comb begin
    turn = a_mode && (down || cnt == a_per);
    wrap = a_mode ? (a_per == '0 || (cnt == WIDTH'(1) && turn)) : cnt == a_per;
    // disabled cycles count as transfer points so pending values apply immediately
    bnd = !enable || !run || wrap;
    n_per = update ? period : pv ? p_per : a_per;
    n_duty = update ? duty : pv ? p_duty : a_duty;
    n_mode = update ? center_mode : pv ? p_mode : a_mode;
    cnt_nxt = (!run || wrap) ? '0 : turn ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
    eff_duty = bnd ? n_duty : a_duty;
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++)
      cmp[i] = cnt_nxt < eff_duty[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      down <= 1'b0;
      run <= 1'b0;
      pv <= 1'b0;
      a_per <= '1;
      a_duty <= '0;
      a_mode <= 1'b0;
      p_per <= '0;
      p_duty <= '0;
      p_mode <= 1'b0;
      pwm_out <= '0;
      period_start <= 1'b0;
    end else begin
      if (bnd) begin
        a_per <= n_per;
        a_duty <= n_duty;
        a_mode <= n_mode;
        pv <= 1'b0;
      end else if (update) begin
        p_per <= period;
        p_duty <= duty;
        p_mode <= center_mode;
        pv <= 1'b1;
      end
      if (!enable) begin
        cnt <= '0;
        down <= 1'b0;
        run <= 1'b0;
        pwm_out <= pol;
        period_start <= 1'b0;
      end else begin
        run <= 1'b1;
        cnt <= cnt_nxt;
        down <= !bnd && turn;
        pwm_out <= cmp ^ pol;
        period_start <= bnd;
      end
    end
  end
endmodule
